// File: rtl/zint_pos_pkg.sv
// Shared raster geometry defaults and the INT vectors that zint also uses.
package zint_pos_pkg;

    localparam int unsigned H_TOTAL_DEF = 448;
    localparam int unsigned V_TOTAL_DEF = 320;
    localparam int unsigned CW_DEF      = 9;

    typedef enum logic [7:0] {
        INT_VEC_FRM = 8'hFF,
        INT_VEC_LIN = 8'hFD
    } int_vec_e;

endpackage

// File: rtl/zint_pos_if.sv
// Register-file / zint side signals of the raster-position interrupt source.
interface zint_pos_if
    import zint_pos_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
);

    logic          cen;
    logic [CW-1:0] frm_hpos;
    logic [CW-1:0] frm_vpos;
    logic [CW-1:0] lin_hpos;
    logic          lin_en;
    logic          m1_n;
    logic          iorq_n;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          line_start;
    logic          frame_start;
    logic          int_start_frm;
    logic          int_start_lin;
    logic          intack;

    modport master (
        output cen, frm_hpos, frm_vpos, lin_hpos, lin_en, m1_n, iorq_n,
        input  hcnt, vcnt, line_start, frame_start, int_start_frm, int_start_lin, intack
    );

    modport slave (
        input  cen, frm_hpos, frm_vpos, lin_hpos, lin_en, m1_n, iorq_n,
        output hcnt, vcnt, line_start, frame_start, int_start_frm, int_start_lin, intack
    );

endinterface

// File: rtl/zint_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module zint_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/zint_pos.sv
// Raster counters plus frame/line INT start pulses at programmed positions, and
// the synchronized INT-acknowledge level derived from M1/IORQ.
module zint_pos
    import zint_pos_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF,
    parameter int unsigned CW      = CW_DEF
) (
    input  logic       clk,
    input  logic       res,
    zint_pos_if.slave  bus
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_int_frm;
    logic          r_int_lin;
    logic          r_intack;

    logic [CW-1:0] r_sh_frm_hpos;
    logic [CW-1:0] r_sh_frm_vpos;
    logic [CW-1:0] r_sh_lin_hpos;
    logic          r_sh_lin_en;

    logic w_h_last;
    logic w_v_last;
    logic w_line_wrap;
    logic w_frame_wrap;
    logic w_frm_hit;
    logic w_lin_hit;
    logic w_m1_s;
    logic w_iorq_s;

    always_comb begin
        w_h_last     = (r_hcnt == H_LAST);
        w_v_last     = (r_vcnt == V_LAST);
        w_line_wrap  = bus.cen && w_h_last;
        w_frame_wrap = w_line_wrap && w_v_last;
        // Positions beyond the raster can never equal a live count, so no range check.
        w_frm_hit    = bus.cen && (r_hcnt == r_sh_frm_hpos) && (r_vcnt == r_sh_frm_vpos);
        w_lin_hit    = bus.cen && r_sh_lin_en && (r_hcnt == r_sh_lin_hpos);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (bus.cen) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_int_frm     <= 1'b0;
            r_int_lin     <= 1'b0;
        end else begin
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
            r_int_frm     <= w_frm_hit;
            r_int_lin     <= w_lin_hit;
        end
    end

    // Shadows only move at the frame wrap so a mid-frame write takes effect next frame.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sh_frm_hpos <= '0;
            r_sh_frm_vpos <= '0;
            r_sh_lin_hpos <= '0;
            r_sh_lin_en   <= 1'b0;
        end else if (w_frame_wrap) begin
            r_sh_frm_hpos <= bus.frm_hpos;
            r_sh_frm_vpos <= bus.frm_vpos;
            r_sh_lin_hpos <= bus.lin_hpos;
            r_sh_lin_en   <= bus.lin_en;
        end
    end

    zint_sync2 #(.RST_VAL(1'b1)) u_sync_m1 (
        .i_clk (clk),
        .i_rst (res),
        .i_d   (bus.m1_n),
        .o_q   (w_m1_s)
    );

    zint_sync2 #(.RST_VAL(1'b1)) u_sync_iorq (
        .i_clk (clk),
        .i_rst (res),
        .i_d   (bus.iorq_n),
        .o_q   (w_iorq_s)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_intack <= 1'b0;
        end else begin
            r_intack <= !w_m1_s && !w_iorq_s;
        end
    end

    assign bus.hcnt          = r_hcnt;
    assign bus.vcnt          = r_vcnt;
    assign bus.line_start    = r_line_start;
    assign bus.frame_start   = r_frame_start;
    assign bus.int_start_frm = r_int_frm;
    assign bus.int_start_lin = r_int_lin;
    assign bus.intack        = r_intack;

endmodule

// File: tb/tb_zint_pos.sv
// Randomized self-checking bench for zint_pos on a reduced raster, against a tick-count model.
module tb_zint_pos;

    localparam int unsigned TB_H  = 24;
    localparam int unsigned TB_V  = 10;
    localparam int unsigned CW    = 9;
    localparam int unsigned FRAME = TB_H * TB_V;

    logic clk;
    logic res;
    int   total;
    int   bad;

    zint_pos_if #(.CW(CW)) bus ();

    zint_pos #(.H_TOTAL(TB_H), .V_TOTAL(TB_V), .CW(CW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: raster position is the number of cen ticks since reset, folded by H and V.
    int unsigned   m_ticks;
    logic [CW-1:0] m_sh_fh, m_sh_fv, m_sh_lh;
    logic          m_sh_len;
    logic          m_ls, m_fs, m_frm, m_lin;
    logic [2:0]    m_hist;

    always @(posedge clk or posedge res) begin : model
        int unsigned h, v;
        if (res) begin
            m_ticks  = 0;
            m_sh_fh  = '0;
            m_sh_fv  = '0;
            m_sh_lh  = '0;
            m_sh_len = 1'b0;
            m_ls     = 1'b0;
            m_fs     = 1'b0;
            m_frm    = 1'b0;
            m_lin    = 1'b0;
            m_hist   = '0;
        end else begin
            h     = m_ticks % TB_H;
            v     = (m_ticks / TB_H) % TB_V;
            m_ls  = bus.cen && (h == TB_H - 1);
            m_fs  = m_ls && (v == TB_V - 1);
            m_frm = bus.cen && (32'(m_sh_fh) == h) && (32'(m_sh_fv) == v);
            m_lin = bus.cen && m_sh_len && (32'(m_sh_lh) == h);
            if (m_fs) begin
                m_sh_fh  = bus.frm_hpos;
                m_sh_fv  = bus.frm_vpos;
                m_sh_lh  = bus.lin_hpos;
                m_sh_len = bus.lin_en;
            end
            if (bus.cen) m_ticks = m_ticks + 1;
            m_hist = {m_hist[1:0], (!bus.m1_n && !bus.iorq_n)};
        end
    end

    logic [2*CW+4:0] obs, expv;
    int unsigned     m_h, m_v;
    assign m_h  = m_ticks % TB_H;
    assign m_v  = (m_ticks / TB_H) % TB_V;
    assign obs  = {bus.hcnt, bus.vcnt, bus.line_start, bus.frame_start,
                   bus.int_start_frm, bus.int_start_lin, bus.intack};
    assign expv = {CW'(m_h), CW'(m_v), m_ls, m_fs, m_frm, m_lin, m_hist[2]};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%h exp=0", i, obs);
            end
        end
        #2 res = 1'b0;
    endtask

    task automatic test_freerun();
        int last_fs, last_ls, frm_cnt;
        bus.frm_hpos = '0;
        bus.frm_vpos = '0;
        bus.lin_en   = 1'b0;
        bus.cen      = 1'b1;
        last_fs = -1;
        last_ls = -1;
        frm_cnt = 0;
        for (int i = 0; i < int'(2 * FRAME) + 40; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL freerun_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            if (bus.line_start) begin
                if (last_ls >= 0) begin
                    total++;
                    if (i - last_ls != int'(TB_H)) begin
                        bad++;
                        $display("FAIL line_period got=%0d exp=%0d", i - last_ls, TB_H);
                    end
                end
                last_ls = i;
            end
            if (bus.frame_start) begin
                if (last_fs >= 0) begin
                    total++;
                    if (i - last_fs != int'(FRAME)) begin
                        bad++;
                        $display("FAIL frame_period got=%0d exp=%0d", i - last_fs, FRAME);
                    end
                    total++;
                    if (frm_cnt != 1) begin
                        bad++;
                        $display("FAIL frm_per_frame got=%0d exp=1", frm_cnt);
                    end
                end
                last_fs = i;
                frm_cnt = 0;
            end
            if (bus.int_start_frm) frm_cnt++;
        end
        total++;
        if (last_fs < 0) begin
            bad++;
            $display("FAIL freerun_no_frame_start got=none exp=pulse");
        end
    endtask

    task automatic test_line_int();
        int cnt;
        bit seen;
        bus.lin_hpos = CW'(7);
        bus.lin_en   = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(FRAME) + 10 && !seen; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL line_wait_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            seen = bus.frame_start;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL line_wait_timeout got=none exp=frame_start");
        end
        cnt = 0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL line_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            if (bus.int_start_lin) begin
                cnt++;
                total++;
                if (bus.hcnt !== CW'(8)) begin
                    bad++;
                    $display("FAIL line_latency got=hcnt %0d exp=8", bus.hcnt);
                end
            end
        end
        total++;
        if (cnt != int'(TB_V)) begin
            bad++;
            $display("FAIL line_count got=%0d exp=%0d", cnt, TB_V);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL line_mid_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
        bus.lin_en = 1'b0;
        cnt  = 0;
        seen = 0;
        for (int i = 0; i < int'(FRAME) && !seen; i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL line_off_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            if (bus.int_start_lin) cnt++;
            seen = bus.frame_start;
        end
        total++;
        if (cnt == 0) begin
            bad++;
            $display("FAIL line_off_early got=0 exp=nonzero");
        end
        cnt = 0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            if (bus.int_start_lin) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL line_off_next_frame got=%0d exp=0", cnt);
        end
    endtask

    task automatic test_out_of_range();
        int cnt;
        for (int phase = 0; phase < 2; phase++) begin
            bus.frm_hpos = (phase == 0) ? CW'(30) : CW'(5);
            bus.frm_vpos = (phase == 0) ? CW'(3)  : CW'(400);
            bus.lin_hpos = CW'(100);
            bus.lin_en   = 1'b1;
            for (int i = 0; i < int'(FRAME) + 1; i++) step();
            cnt = 0;
            for (int i = 0; i < int'(2 * FRAME); i++) begin
                step();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL oor_model ph=%0d cyc=%0d got=%h exp=%h", phase, i, obs, expv);
                end
                if (bus.int_start_frm || bus.int_start_lin) cnt++;
            end
            total++;
            if (cnt != 0) begin
                bad++;
                $display("FAIL oor_pulses ph=%0d got=%0d exp=0", phase, cnt);
            end
        end
    endtask

    task automatic test_cen_sparse();
        int  frm_cnt;
        bit  prev_frm, prev_lin;
        bus.frm_hpos = CW'($urandom_range(TB_H - 1));
        bus.frm_vpos = CW'($urandom_range(TB_V - 1));
        bus.lin_hpos = CW'($urandom_range(TB_H - 1));
        bus.lin_en   = 1'b1;
        frm_cnt  = 0;
        prev_frm = 0;
        prev_lin = 0;
        for (int i = 0; i < int'(12 * FRAME); i++) begin
            bus.cen = (i % 4 == 0);
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL sparse_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            if (bus.int_start_frm || bus.int_start_lin) begin
                total++;
                if ((bus.int_start_frm && prev_frm) || (bus.int_start_lin && prev_lin)) begin
                    bad++;
                    $display("FAIL sparse_width cyc=%0d got=stretched exp=1clk", i);
                end
            end
            if (bus.int_start_frm) frm_cnt++;
            prev_frm = bus.int_start_frm;
            prev_lin = bus.int_start_lin;
        end
        total++;
        if (frm_cnt < 1) begin
            bad++;
            $display("FAIL sparse_frm_count got=%0d exp>=1", frm_cnt);
        end
        bus.cen = 1'b1;
    endtask

    task automatic test_intack();
        int hi_cnt, first_hi;
        hi_cnt   = 0;
        first_hi = -1;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) #1 bus.m1_n = 1'b0;
            if (c == 1) #3 bus.iorq_n = 1'b0;
            if (c == 7) #2 bus.iorq_n = 1'b1;
            if (c == 8) #4 bus.m1_n = 1'b1;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL intack_model cyc=%0d got=%h exp=%h", c, obs, expv);
            end
            if (bus.intack) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
            end
        end
        total++;
        if (first_hi != 3) begin
            bad++;
            $display("FAIL intack_latency got=%0d exp=3", first_hi);
        end
        total++;
        if (hi_cnt != 6) begin
            bad++;
            $display("FAIL intack_width got=%0d exp=6", hi_cnt);
        end
        hi_cnt = 0;
        #2 bus.m1_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.intack) hi_cnt++;
        end
        bus.m1_n = 1'b1;
        total++;
        if (hi_cnt != 0) begin
            bad++;
            $display("FAIL intack_m1_only got=%0d exp=0", hi_cnt);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            bus.cen = 1'($urandom_range(1));
            if ($urandom_range(49) == 0) begin
                bus.frm_hpos = CW'($urandom_range(1) != 0 ? $urandom_range(TB_H - 1) : $urandom_range(511));
                bus.frm_vpos = CW'($urandom_range(1) != 0 ? $urandom_range(TB_V - 1) : $urandom_range(511));
                bus.lin_hpos = CW'($urandom_range(1) != 0 ? $urandom_range(TB_H - 1) : $urandom_range(511));
                bus.lin_en   = 1'($urandom_range(1));
            end
            if ($urandom_range(7) == 0) bus.m1_n   = ~bus.m1_n;
            if ($urandom_range(7) == 0) bus.iorq_n = ~bus.iorq_n;
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
        end
        bus.m1_n   = 1'b1;
        bus.iorq_n = 1'b1;
        bus.cen    = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset_midframe();
        bit seen;
        int first_frm, frm_cnt;
        bus.frm_hpos = CW'(5);
        bus.frm_vpos = CW'(2);
        bus.cen      = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(FRAME) + 10 && !seen; i++) begin
            step();
            seen = bus.frame_start;
        end
        seen = 0;
        for (int i = 0; i < int'(FRAME) + 10 && !seen; i++) begin
            step();
            seen = (m_h == 13) && (m_v == 5);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midreset_wait_timeout got=none exp=13,5");
        end
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL midreset_pre got=%h exp=%h", obs, expv);
        end
        #2 res = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midreset_immediate got=%h exp=0", obs);
        end
        step();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL midreset_hold got=%h exp=0", obs);
        end
        #2 res = 1'b0;
        first_frm = -1;
        frm_cnt   = 0;
        for (int i = 0; i < int'(FRAME); i++) begin
            step();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", i, obs, expv);
            end
            if (bus.int_start_frm) begin
                frm_cnt++;
                if (first_frm < 0) begin
                    first_frm = i;
                    total++;
                    if (bus.hcnt !== CW'(1) || bus.vcnt !== '0) begin
                        bad++;
                        $display("FAIL midreset_frm_pos got=%0d,%0d exp=1,0", bus.hcnt, bus.vcnt);
                    end
                end
            end
        end
        total++;
        if (first_frm != 0 || frm_cnt != 1) begin
            bad++;
            $display("FAIL midreset_frm got=first %0d cnt %0d exp=first 0 cnt 1", first_frm, frm_cnt);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        res          = 1'b1;
        bus.cen      = 1'b0;
        bus.frm_hpos = '0;
        bus.frm_vpos = '0;
        bus.lin_hpos = '0;
        bus.lin_en   = 1'b0;
        bus.m1_n     = 1'b1;
        bus.iorq_n   = 1'b1;
        test_reset();
        test_freerun();
        test_line_int();
        test_out_of_range();
        test_cen_sparse();
        test_intack();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
